// File: rtl/apb_pkg.sv
// Shared APB bridge types and defaults: bus widths, default peripheral map and FSM state encoding.
// No logic; imported by the decoder and the bridge.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam int                    APB_NUM_SLAVES  = 4;
  localparam logic [APB_ADDR_W-1:0] APB_BASE_ADDR   = 32'h1000_0000;
  localparam int                    APB_REGION_BITS = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERR    = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// Peripheral window decoder: byte address -> hit flag, one-hot slave select, in-region offset.
// Purely combinational (0 cycles); no flow control.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int                    NUM_SLAVES  = APB_NUM_SLAVES,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = APB_BASE_ADDR,
  parameter int                    REGION_BITS = APB_REGION_BITS
) (
  input  logic [APB_ADDR_W-1:0] i_addr,
  output logic                  o_hit,
  output logic [NUM_SLAVES-1:0] o_sel,
  output logic [APB_ADDR_W-1:0] o_offset
);

  logic [2:0] w_idx;
  logic       w_tag_hit;

  assign w_idx     = i_addr[REGION_BITS+2:REGION_BITS];
  assign w_tag_hit = (i_addr[APB_ADDR_W-1:REGION_BITS+3] == BASE_ADDR[APB_ADDR_W-1:REGION_BITS+3]);
  // The 3-bit index can name up to 8 regions; only the populated ones count as hits.
  assign o_hit     = w_tag_hit && ({1'b0, w_idx} < 4'(NUM_SLAVES));
  assign o_offset  = {{(APB_ADDR_W-REGION_BITS){1'b0}}, i_addr[REGION_BITS-1:0]};

  always_comb begin
    o_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      o_sel[i] = o_hit && (w_idx == 3'(i));
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 initiator: one request at a time, SETUP/ACCESS, response 3 cycles after accept (+1 per wait, 2 on miss).
// req_ready only in IDLE, rsp has no backpressure; `APB_MASTER_TIMEOUT_EN adds an ACCESS wait limit.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int                    NUM_SLAVES     = APB_NUM_SLAVES,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR      = APB_BASE_ADDR,
  parameter int                    REGION_BITS    = APB_REGION_BITS,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [APB_ADDR_W-1:0]            req_addr,
  input  logic [APB_DATA_W-1:0]            req_wdata,
  output logic                             rsp_valid,
  output logic [APB_DATA_W-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [APB_ADDR_W-1:0]            PADDR,
  output logic                             PWRITE,
  output logic                             PENABLE,
  output logic [APB_DATA_W-1:0]            PWDATA,
  output logic [NUM_SLAVES-1:0]            PSEL,
  input  logic [NUM_SLAVES*APB_DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_master_bridge: NUM_SLAVES must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

  apb_state_e            r_state;
  logic [NUM_SLAVES-1:0] r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [APB_ADDR_W-1:0] r_paddr;
  logic [APB_DATA_W-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [APB_DATA_W-1:0] r_rsp_rdata;

  logic                  w_hit;
  logic [NUM_SLAVES-1:0] w_sel;
  logic [APB_ADDR_W-1:0] w_offset;
  logic                  w_pready;
  logic [APB_DATA_W-1:0] w_prdata;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_wait_cnt;
`endif

  apb_addr_decoder #(
    .NUM_SLAVES  (NUM_SLAVES),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_BITS (REGION_BITS)
  ) u_dec (
    .i_addr   (req_addr),
    .o_hit    (w_hit),
    .o_sel    (w_sel),
    .o_offset (w_offset)
  );

  // r_psel doubles as the latched slave index, so ready/data steering needs no decode.
  assign w_pready = |(PREADY & r_psel);

  always_comb begin
    w_prdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_psel[i]) w_prdata = w_prdata | PRDATA[APB_DATA_W*i +: APB_DATA_W];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      r_wait_cnt  <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_pwrite <= req_write;
            r_paddr  <= w_offset;
            r_pwdata <= req_wdata;
            r_psel   <= w_sel;
            r_state  <= w_hit ? SETUP : ERR;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          // A ready slave takes priority over the wait limit in the same cycle.
          if (w_pready) begin
            r_rsp_rdata <= r_pwrite ? '0 : w_prdata;
            r_rsp_valid <= 1'b1;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_state     <= IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (r_wait_cnt == CNT_LAST) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_state   <= ERR;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        ERR: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b1;
          r_rsp_rdata <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE) && !PRESET;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;

endmodule
